// File: rtl/fir_tap_para_fetch.sv
// FIR parameter prefetcher: fetches one table per track from DDR, buffers it,
// and streams it to fir_ctrl one 32-bit word per cycle while ren is held.
module fir_tap_para_fetch #(
  parameter int DDR_DW      = 256,
  parameter int BURST_LEN   = 16,
  parameter int TABLE_BYTES = 512,
  parameter int TABLE_NUM   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              laser_start_i,
  input  logic [31:0]       table_base_i,
  output logic              ddr_rd_cmd_vld_o,
  input  logic              ddr_rd_cmd_rdy_i,
  output logic [31:0]       ddr_rd_cmd_addr_o,
  output logic [7:0]        ddr_rd_cmd_len_o,
  input  logic              ddr_rd_data_vld_i,
  input  logic [DDR_DW-1:0] ddr_rd_data_i,
  input  logic              fir_tap_para_ren_i,
  output logic              fir_tap_para_vld_o,
  output logic [31:0]       fir_tap_para_data_o,
  output logic              fir_tap_ready_o
);

  localparam int WPB    = DDR_DW / 32;
  localparam int WORDS  = BURST_LEN * WPB;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int BSEL_W = $clog2(BURST_LEN);
  localparam int WSEL_W = $clog2(WPB);
  localparam int PTR_W  = $clog2(WORDS + 1);
  localparam int IDX_W  = (TABLE_NUM > 1) ? $clog2(TABLE_NUM) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT, S_READY, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic                laser_q, ren_q;
  logic [31:0]         base_q;
  logic [IDX_W-1:0]    idx_q;
  logic [BEAT_W-1:0]   beat_cnt_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic                popped_q;
  logic                vld_q;
  logic [31:0]         data_q;
  logic [DDR_DW-1:0]   mem [BURST_LEN];

  logic start_rise, start_fall, ren_fall, cmd_acc, beat_in, last_beat;
  logic release_tbl, draining_q, draining_d, avail, pop;

  assign start_rise  = laser_start_i & ~laser_q;
  assign start_fall  = ~laser_start_i & laser_q;
  assign ren_fall    = ~fir_tap_para_ren_i & ren_q;
  assign cmd_acc     = (state_q == S_CMD) & ddr_rd_cmd_rdy_i;
  assign beat_in     = ddr_rd_data_vld_i & ((state_q == S_WAIT) | (state_q == S_FLUSH));
  assign last_beat   = beat_in & (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
  assign draining_q  = (state_q == S_WAIT) | (state_q == S_READY);
  assign draining_d  = (state_d == S_WAIT) | (state_d == S_READY);
  assign release_tbl = ren_fall & popped_q & draining_q;
  // A word is available once the beat holding it has been written.
  assign avail       = rd_ptr_q < PTR_W'(beat_cnt_q) * PTR_W'(WPB);
  assign pop         = fir_tap_para_ren_i & avail & draining_q & draining_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_rise) state_d = S_CMD;
      S_CMD: begin
        if (start_fall)      state_d = cmd_acc ? S_FLUSH : S_IDLE;
        else if (start_rise) state_d = cmd_acc ? S_FLUSH : S_CMD;
        else if (cmd_acc)    state_d = S_WAIT;
      end
      S_WAIT: begin
        // Any exit before the burst completes must swallow the remaining beats.
        if (start_rise || start_fall || release_tbl)
          state_d = last_beat ? (laser_start_i ? S_CMD : S_IDLE) : S_FLUSH;
        else if (last_beat)
          state_d = S_READY;
      end
      S_READY: begin
        if (start_fall)                      state_d = S_IDLE;
        else if (start_rise || release_tbl)  state_d = S_CMD;
      end
      S_FLUSH: if (last_beat) state_d = laser_start_i ? S_CMD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ddr_rd_cmd_vld_o = 1'b0;
    fir_tap_ready_o  = 1'b0;
    if (state_q == S_CMD)                ddr_rd_cmd_vld_o = 1'b1;
    if (state_q == S_READY && !popped_q) fir_tap_ready_o  = 1'b1;
  end

  assign ddr_rd_cmd_addr_o   = base_q + 32'(idx_q) * 32'(TABLE_BYTES);
  assign ddr_rd_cmd_len_o    = 8'(BURST_LEN - 1);
  assign fir_tap_para_vld_o  = vld_q;
  assign fir_tap_para_data_o = data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      laser_q    <= 1'b0;
      ren_q      <= 1'b0;
      base_q     <= '0;
      idx_q      <= '0;
      beat_cnt_q <= '0;
      rd_ptr_q   <= '0;
      popped_q   <= 1'b0;
      vld_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      laser_q <= laser_start_i;
      ren_q   <= fir_tap_para_ren_i;

      // Restart takes priority over a simultaneous release.
      if (start_rise) begin
        base_q <= table_base_i;
        idx_q  <= '0;
      end else if (release_tbl) begin
        idx_q <= (idx_q == IDX_W'(TABLE_NUM - 1)) ? '0 : idx_q + IDX_W'(1);
      end

      if (state_d == S_CMD || state_d == S_IDLE) beat_cnt_q <= '0;
      else if (beat_in)                          beat_cnt_q <= beat_cnt_q + BEAT_W'(1);

      if (!draining_d) begin
        rd_ptr_q <= '0;
        popped_q <= 1'b0;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        popped_q <= 1'b1;
      end

      vld_q <= pop;
      if (pop)
        data_q <= mem[rd_ptr_q[WSEL_W +: BSEL_W]][{rd_ptr_q[WSEL_W-1:0], 5'b0} +: 32];
    end
  end

  // NOTE: the beat buffer has no reset; beat_cnt_q gates every read, so
  // stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (beat_in && state_q == S_WAIT)
      mem[beat_cnt_q[BSEL_W-1:0]] <= ddr_rd_data_i;
  end

endmodule

// File: tb/tb_fir_tap_para_fetch.sv
// Scoreboard bench for fir_tap_para_fetch: stimulus queues expected words and
// command addresses, independent monitors compare them as the DUT emits them.
module tb_fir_tap_para_fetch;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         laser_start_i;
  logic [31:0]  table_base_i;
  logic         ddr_rd_cmd_vld_o;
  logic         ddr_rd_cmd_rdy_i;
  logic [31:0]  ddr_rd_cmd_addr_o;
  logic [7:0]   ddr_rd_cmd_len_o;
  logic         ddr_rd_data_vld_i;
  logic [255:0] ddr_rd_data_i;
  logic         fir_tap_para_ren_i;
  logic         fir_tap_para_vld_o;
  logic [31:0]  fir_tap_para_data_o;
  logic         fir_tap_ready_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_words[$];
  logic [31:0] exp_cmds[$];

  fir_tap_para_fetch #(.TABLE_NUM(4)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .laser_start_i       (laser_start_i),
    .table_base_i        (table_base_i),
    .ddr_rd_cmd_vld_o    (ddr_rd_cmd_vld_o),
    .ddr_rd_cmd_rdy_i    (ddr_rd_cmd_rdy_i),
    .ddr_rd_cmd_addr_o   (ddr_rd_cmd_addr_o),
    .ddr_rd_cmd_len_o    (ddr_rd_cmd_len_o),
    .ddr_rd_data_vld_i   (ddr_rd_data_vld_i),
    .ddr_rd_data_i       (ddr_rd_data_i),
    .fir_tap_para_ren_i  (fir_tap_para_ren_i),
    .fir_tap_para_vld_o  (fir_tap_para_vld_o),
    .fir_tap_para_data_o (fir_tap_para_data_o),
    .fir_tap_ready_o     (fir_tap_ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_word(input int tag, input int n);
    return {8'hC0, 8'(tag), 8'h5A, 8'(n)};
  endfunction

  function automatic logic [255:0] mk_beat(input int tag, input int b);
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = mk_word(tag, b * 8 + w);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int tag, input int count);
    for (int n = 0; n < count; n++) exp_words.push_back(mk_word(tag, n));
  endtask

  task automatic send_beats(input int tag, input int first, input int n, input int gap);
    for (int b = first; b < first + n; b++) begin
      tick();
      ddr_rd_data_vld_i = 1'b1;
      ddr_rd_data_i     = mk_beat(tag, b);
      for (int g = 0; g < gap; g++) begin
        tick();
        ddr_rd_data_vld_i = 1'b0;
      end
    end
    tick();
    ddr_rd_data_vld_i = 1'b0;
  endtask

  // Returns at the negedge where a handshake is visible; it completes on the next posedge.
  task automatic wait_cmd(input string name);
    logic seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = ddr_rd_cmd_vld_o & ddr_rd_cmd_rdy_i;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Word scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && fir_tap_para_vld_o) begin
        if (exp_words.size() == 0) begin
          check("unexpected_word", fir_tap_para_data_o, 32'hxxxx_xxxx);
        end else begin
          check("word", fir_tap_para_data_o, exp_words.pop_front());
        end
      end
    end
  end

  // Command scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && ddr_rd_cmd_vld_o && ddr_rd_cmd_rdy_i) begin
        check("cmd_len", 32'(ddr_rd_cmd_len_o), 32'd15);
        if (exp_cmds.size() == 0) check("unexpected_cmd", ddr_rd_cmd_addr_o, 32'hxxxx_xxxx);
        else                      check("cmd_addr", ddr_rd_cmd_addr_o, exp_cmds.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, cnt;
    bit seen;

    rst_i = 1'b1;
    laser_start_i = 1'b0;
    table_base_i = 32'h1000;
    ddr_rd_cmd_rdy_i = 1'b1;
    ddr_rd_data_vld_i = 1'b0;
    ddr_rd_data_i = '0;
    fir_tap_para_ren_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("rst_cmd_vld", 32'(ddr_rd_cmd_vld_o), 32'd0);
    check("rst_cmd_addr", ddr_rd_cmd_addr_o, 32'd0);
    check("rst_vld", 32'(fir_tap_para_vld_o), 32'd0);
    check("rst_data", fir_tap_para_data_o, 32'd0);
    check("rst_ready", 32'(fir_tap_ready_o), 32'd0);
    check("rst_len", 32'(ddr_rd_cmd_len_o), 32'd15);

    // Table 0: full burst, then drain all 128 words with 1-clk latency.
    exp_cmds.push_back(32'h1000);
    laser_start_i = 1'b1;
    wait_cmd("t1_cmd");
    send_beats(1, 0, 16, 0);
    check("t1_ready", 32'(fir_tap_ready_o), 32'd1);
    push_words(1, 128);
    fir_tap_para_ren_i = 1'b1;
    @(negedge clk);
    check("t1_lat_pre", 32'(fir_tap_para_vld_o), 32'd0);
    @(negedge clk);
    check("t1_lat_first", 32'(fir_tap_para_vld_o), 32'd1);
    check("t1_ready_drop", 32'(fir_tap_ready_o), 32'd0);
    cnt = 0;
    for (int i = 0; i < 127; i++) begin
      @(negedge clk);
      if (fir_tap_para_vld_o) cnt++;
    end
    check("t1_consecutive", 32'(cnt), 32'd127);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fir_tap_para_vld_o || ddr_rd_cmd_vld_o) cnt++;
    end
    check("t1_hold_until_ren_fall", 32'(cnt), 32'd0);
    exp_cmds.push_back(32'h1200);
    tick();
    fir_tap_para_ren_i = 1'b0;

    // Table 1: stop after 127 words, residual flushed, next table follows.
    wait_cmd("t2_cmd");
    send_beats(2, 0, 16, 0);
    check("t2_ready", 32'(fir_tap_ready_o), 32'd1);
    push_words(2, 127);
    fir_tap_para_ren_i = 1'b1;
    repeat (127) tick();
    exp_cmds.push_back(32'h1400);
    fir_tap_para_ren_i = 1'b0;

    // Table 2: ren held before data; sparse beats give 8-word bursts with 2-cycle gaps.
    wait_cmd("t3_cmd");
    fir_tap_para_ren_i = 1'b1;
    push_words(3, 128);
    hi = 0; lo = 0; seen = 1'b0;
    fork
      send_beats(3, 0, 16, 9);
      for (int c = 0; c < 250 && hi < 128; c++) begin
        @(negedge clk);
        if (fir_tap_para_vld_o) begin
          hi++;
          seen = 1'b1;
        end else if (seen) begin
          lo++;
        end
      end
    join
    check("t3_words", 32'(hi), 32'd128);
    check("t3_gaps", 32'(lo), 32'd30);
    exp_cmds.push_back(32'h1600);
    tick();
    fir_tap_para_ren_i = 1'b0;

    // Table 3: partial read; index wraps back to table 0 (TABLE_NUM=4).
    wait_cmd("t5_cmd3");
    send_beats(4, 0, 16, 0);
    push_words(4, 10);
    fir_tap_para_ren_i = 1'b1;
    repeat (10) tick();
    exp_cmds.push_back(32'h1000);
    fir_tap_para_ren_i = 1'b0;
    wait_cmd("t5_wrap_cmd");

    // Restart with 5 of 16 beats received: rest discarded, new base fetched.
    send_beats(5, 0, 5, 0);
    laser_start_i = 1'b0;
    tick();
    laser_start_i = 1'b1;
    table_base_i = 32'h8000;
    fir_tap_para_ren_i = 1'b1;
    exp_cmds.push_back(32'h8000);
    cnt = 0;
    fork
      send_beats(5, 5, 11, 0);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (fir_tap_para_vld_o) cnt++;
      end
    join
    check("t4_no_vld_in_flush", 32'(cnt), 32'd0);
    fir_tap_para_ren_i = 1'b0;
    check("t4_addr_hold", ddr_rd_cmd_addr_o, 32'h8000);

    // Asynchronous reset in the middle of a burst.
    send_beats(6, 0, 3, 0);
    check("t6_data_before_rst", fir_tap_para_data_o, mk_word(4, 9));
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    laser_start_i = 1'b0;
    #1;
    check("t6_cmd_vld", 32'(ddr_rd_cmd_vld_o), 32'd0);
    check("t6_cmd_addr", ddr_rd_cmd_addr_o, 32'd0);
    check("t6_vld", 32'(fir_tap_para_vld_o), 32'd0);
    check("t6_data", fir_tap_para_data_o, 32'd0);
    check("t6_ready", 32'(fir_tap_ready_o), 32'd0);
    repeat (2) tick();
    rst_i = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ddr_rd_cmd_vld_o || fir_tap_para_vld_o || fir_tap_ready_o) cnt++;
    end
    check("t6_idle_after_rst", 32'(cnt), 32'd0);
    table_base_i = 32'h3000;
    exp_cmds.push_back(32'h3000);
    tick();
    laser_start_i = 1'b1;
    wait_cmd("t6_restart_cmd");
    repeat (3) tick();

    check("words_left", 32'(exp_words.size()), 32'd0);
    check("cmds_left", 32'(exp_cmds.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
